bti_tcm: RTL and testbench
==========================

// Module: bti_tcm
// PURPOSE
//   Tightly-coupled memory slave for the core's BTI ports; one instance each
//   serves the ITCM (fetch) and DTCM (load/store) BTI request/response pair
//   driven by the core's bus interface unit. Word-organised storage with byte
//   write strobes, 1-cycle read latency and a small response FIFO so response
//   backpressure never forces a combinational path back to req_rdy.
// PARAMETERS
//   DEPTH_WORDS     4096        storage size in 32-bit words (power of 2)
//   BASE_ADDR       32'h0000_0000  byte base address; aligned to DEPTH_WORDS*4
//   RSP_FIFO_DEPTH  2           response FIFO entries (power of 2, >=2)
// PORTS
//   clk        in   1   core clock
//   rst_n      in   1   asynchronous active-low reset
//   req_vld    in   1   request valid
//   req_rdy    out  1   request ready
//   req_addr   in   32  byte address
//   req_wr     in   1   1 = write, 0 = read
//   req_wdata  in   32  write data
//   req_wstrb  in   4   byte enables, bit i -> wdata[8i+7:8i]
//   rsp_vld    out  1   response valid
//   rsp_rdy    in   1   response ready
//   rsp_rdata  out  32  read data (0 for writes and errors)
//   rsp_err    out  1   access fault
// BEHAVIOUR
//   - One clock; reset is asynchronous and active-low. Reset values:
//     req_rdy=0 while rst_n=0, 1 after; rsp_vld=0, rsp_rdata=0, rsp_err=0,
//     FIFO count/pointers=0. Storage array is NOT reset (contents undefined).
//   - Request handshake: accept when req_vld & req_rdy at a rising edge.
//     req_rdy = (fifo_cnt != RSP_FIFO_DEPTH); registered, independent of rsp_rdy.
//   - Decode: idx = req_addr[2 +: log2(DEPTH_WORDS)].
//     err = (req_addr[1:0] != 0) | (req_addr[31:2+log2(DEPTH_WORDS)] !=
//     BASE_ADDR[31:2+log2(DEPTH_WORDS)]). Write with req_wstrb==0 is legal no-op.
//   - Access at the accept edge: read captures mem[idx]; write updates only
//     strobed bytes. Erroring accesses never modify storage.
//   - Response entry {rdata, err} pushed at the accept edge; rsp_vld=1 in the
//     next cycle if FIFO was empty (latency exactly 1 cycle). Responses strictly
//     in request order, one response per accepted request.
//   - Response handshake: entry popped when rsp_vld & rsp_rdy; rsp_* driven
//     from FIFO head, held stable while rsp_vld & !rsp_rdy.
//   - Simultaneous push and pop: count unchanged; FIFO full with pop in same
//     cycle still deasserts req_rdy that cycle (no ready-through-pop).
//   - Pointers wrap modulo RSP_FIFO_DEPTH; count range 0..RSP_FIFO_DEPTH.
//   - Read-after-write to same word on back-to-back cycles returns new data.
//   - Full throughput: with rsp_rdy held high, one request per cycle sustained.
//   - Reset asserted mid-operation: FIFO flushed, pending responses dropped,
//     outputs return to reset values immediately; storage retains contents.
//   - X on req_* while req_vld=0 must not affect state.
// TESTING
//   1 Write 0xDEADBEEF strobe 4'hF to 0x10, read 0x10 -> rsp 1 cycle after
//     accept: rdata=0xDEADBEEF, err=0; write rsp rdata=0, err=0.
//   2 Write 0x000000AA strb 4'h1 then 0x0000BB00 strb 4'h2 to 0x20 over
//     0x11223344 -> read returns 0x1122BBAA.
//   3 Read 0x13 (misaligned) and BASE_ADDR+DEPTH_WORDS*4 -> err=1, rdata=0;
//     write to out-of-range address leaves storage unchanged (readback check).
//   4 rsp_rdy=0, issue 3 reads back-to-back -> 2 accepted, req_rdy=0 on 3rd;
//     release rsp_rdy -> responses in order, 3rd accepted after first pop.
//   5 rsp_rdy=1, 16 consecutive reads of distinct words -> 16 accepts in
//     16 cycles, responses in order, no bubbles.
//   6 Assert rst_n=0 with 2 responses queued -> rsp_vld=0 same cycle; after
//     release, no stale responses; earlier written data still readable.

Source files
------------

// File: rtl/bti_tcm.sv
// bti_tcm: tightly-coupled memory slave on a BTI request/response pair.
// Word storage with byte strobes. The read is captured at the accept edge and
// pushed into a small response FIFO. req_rdy comes only from the registered
// FIFO count, so rsp_rdy never reaches req_rdy through a combinational path.
module bti_tcm #(
    parameter int unsigned DEPTH_WORDS    = 4096,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned RSP_FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_vld,
    output logic        req_rdy,
    input  logic [31:0] req_addr,
    input  logic        req_wr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_vld,
    input  logic        rsp_rdy,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned PTR_W = $clog2(RSP_FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RSP_FIFO_DEPTH);

    logic [31:0]               mem [DEPTH_WORDS];
    logic [31:0]               fifo_rdata [RSP_FIFO_DEPTH];
    logic [RSP_FIFO_DEPTH-1:0] fifo_err;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rdy_q, rdy_d;

    logic [IDX_W-1:0] idx;
    logic             acc_err;
    logic             push;
    logic             pop;
    logic             mem_we;
    logic [31:0]      push_rdata;

    // Address decode, handshakes and the data captured into the FIFO
    always_comb begin
        idx        = req_addr[2 +: IDX_W];
        acc_err    = (req_addr[1:0] != 2'b00) |
                     (req_addr[31:2+IDX_W] != BASE_ADDR[31:2+IDX_W]);
        push       = req_vld & rdy_q;
        pop        = (cnt_q != '0) & rsp_rdy;
        mem_we     = push & req_wr & ~acc_err;
        push_rdata = (req_wr | acc_err) ? 32'h0 : mem[idx];
    end

    // FIFO pointer/count next state; ready looks at the post-edge count
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        rdy_d = (cnt_d != FULL_CNT);
    end

    // Control state; reset flushes any pending responses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            rdy_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            rdy_q    <= rdy_d;
        end
    end

    // Storage is deliberately not reset so contents survive rst_n
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_we && req_wstrb[b]) begin
                mem[idx][8*b +: 8] <= req_wdata[8*b +: 8];
            end
        end
    end

    // FIFO payload; validity is tracked by cnt_q, so no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rdata[wr_ptr_q] <= push_rdata;
            fifo_err[wr_ptr_q]   <= acc_err;
        end
    end

    // Outputs driven from the FIFO head, forced to zero when empty
    always_comb begin
        req_rdy   = rdy_q;
        rsp_vld   = (cnt_q != '0);
        rsp_rdata = rsp_vld ? fifo_rdata[rd_ptr_q] : 32'h0;
        rsp_err   = rsp_vld ? fifo_err[rd_ptr_q] : 1'b0;
    end

endmodule

// File: tb/tb_bti_tcm.sv
// tb_bti_tcm: directed, table-driven self-checking bench for bti_tcm.
module tb_bti_tcm;

    logic        clk;
    logic        rst_n;
    logic        req_vld;
    logic        req_rdy;
    logic [31:0] req_addr;
    logic        req_wr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_vld;
    logic        rsp_rdy;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_cmp  = 0;
    int n_fail = 0;

    bti_tcm #(
        .DEPTH_WORDS   (4096),
        .BASE_ADDR     (32'h0000_0000),
        .RSP_FIFO_DEPTH(2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_vld  (req_vld),
        .req_rdy  (req_rdy),
        .req_addr (req_addr),
        .req_wr   (req_wr),
        .req_wdata(req_wdata),
        .req_wstrb(req_wstrb),
        .rsp_vld  (rsp_vld),
        .rsp_rdy  (rsp_rdy),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock; return 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] s);
        req_vld   = 1'b1;
        req_addr  = a;
        req_wr    = w;
        req_wdata = d;
        req_wstrb = s;
    endtask

    task automatic idle();
        req_vld   = 1'b0;
        req_addr  = 'x;
        req_wr    = 1'bx;
        req_wdata = 'x;
        req_wstrb = 'x;
    endtask

    initial begin
        vecs[0]  = '{32'h10,   1'b1, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        vecs[1]  = '{32'h10,   1'b0, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{32'h20,   1'b1, 32'h11223344, 4'hF, 32'h0,        1'b0};
        vecs[3]  = '{32'h20,   1'b1, 32'h000000AA, 4'h1, 32'h0,        1'b0};
        vecs[4]  = '{32'h20,   1'b1, 32'h0000BB00, 4'h2, 32'h0,        1'b0};
        vecs[5]  = '{32'h20,   1'b0, 32'h0,        4'h0, 32'h1122BBAA, 1'b0};
        vecs[6]  = '{32'h13,   1'b0, 32'h0,        4'h0, 32'h0,        1'b1};
        vecs[7]  = '{32'h4000, 1'b0, 32'h0,        4'h0, 32'h0,        1'b1};
        vecs[8]  = '{32'h4010, 1'b1, 32'h12345678, 4'hF, 32'h0,        1'b1};
        vecs[9]  = '{32'h10,   1'b0, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        vecs[10] = '{32'h11,   1'b1, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
        vecs[11] = '{32'h10,   1'b0, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        vecs[12] = '{32'h30,   1'b1, 32'h00000000, 4'hF, 32'h0,        1'b0};
        vecs[13] = '{32'h30,   1'b1, 32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
        vecs[14] = '{32'h30,   1'b0, 32'h0,        4'h0, 32'h0,        1'b0};
        vecs[15] = '{32'h24,   1'b1, 32'h00000000, 4'hF, 32'h0,        1'b0};
        vecs[16] = '{32'h24,   1'b1, 32'hAABBCCDD, 4'hC, 32'h0,        1'b0};
        vecs[17] = '{32'h24,   1'b0, 32'h0,        4'h0, 32'hAABB0000, 1'b0};

        rst_n   = 1'b0;
        rsp_rdy = 1'b1;
        idle();

        // Reset values
        #1;
        check("rst_req_rdy", {31'b0, req_rdy}, 32'h0);
        check("rst_rsp_vld", {31'b0, rsp_vld}, 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err", {31'b0, rsp_err}, 32'h0);
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
        check("post_rst_req_rdy", {31'b0, req_rdy}, 32'h1);
        check("post_rst_rsp_vld", {31'b0, rsp_vld}, 32'h0);

        // Back-to-back vector table; each response appears 1 cycle after accept
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].addr, vecs[i].wr, vecs[i].wdata, vecs[i].wstrb);
            check($sformatf("v%0d_req_rdy", i), {31'b0, req_rdy}, 32'h1);
            step();
            check($sformatf("v%0d_rsp_vld", i), {31'b0, rsp_vld}, 32'h1);
            check($sformatf("v%0d_rdata", i), rsp_rdata, vecs[i].exp_rdata);
            check($sformatf("v%0d_err", i), {31'b0, rsp_err}, {31'b0, vecs[i].exp_err});
        end
        idle();
        step();
        check("tbl_drain_rsp_vld", {31'b0, rsp_vld}, 32'h0);

        // Backpressure: FIFO fills at 2, third request waits for the first pop
        rsp_rdy = 1'b0;
        drive(32'h10, 1'b0, 32'h0, 4'h0);
        step();
        check("bp_rdy_after1", {31'b0, req_rdy}, 32'h1);
        check("bp_head1", rsp_rdata, 32'hDEADBEEF);
        drive(32'h20, 1'b0, 32'h0, 4'h0);
        step();
        check("bp_rdy_full", {31'b0, req_rdy}, 32'h0);
        drive(32'h24, 1'b0, 32'h0, 4'h0);
        step();
        check("bp_rdy_stall", {31'b0, req_rdy}, 32'h0);
        check("bp_vld_stall", {31'b0, rsp_vld}, 32'h1);
        check("bp_head_stable", rsp_rdata, 32'hDEADBEEF);
        rsp_rdy = 1'b1;
        // Full with a pop this cycle: ready must still be low
        check("bp_no_ready_through_pop", {31'b0, req_rdy}, 32'h0);
        step();
        check("bp_head2", rsp_rdata, 32'h1122BBAA);
        check("bp_rdy_after_pop", {31'b0, req_rdy}, 32'h1);
        step();
        idle();
        check("bp_head3_vld", {31'b0, rsp_vld}, 32'h1);
        check("bp_head3", rsp_rdata, 32'hAABB0000);
        step();
        check("bp_drained", {31'b0, rsp_vld}, 32'h0);

        // Throughput: 16 writes then 16 reads, one per cycle, no bubbles
        for (int i = 0; i < 16; i++) begin
            drive(32'h100 + 32'(4 * i), 1'b1, 32'hA5000000 | 32'(i << 8) | 32'(i), 4'hF);
            check($sformatf("tp_w%0d_rdy", i), {31'b0, req_rdy}, 32'h1);
            step();
            check($sformatf("tp_w%0d_vld", i), {31'b0, rsp_vld}, 32'h1);
        end
        for (int i = 0; i < 16; i++) begin
            drive(32'h100 + 32'(4 * i), 1'b0, 32'h0, 4'h0);
            check($sformatf("tp_r%0d_rdy", i), {31'b0, req_rdy}, 32'h1);
            step();
            check($sformatf("tp_r%0d_vld", i), {31'b0, rsp_vld}, 32'h1);
            check($sformatf("tp_r%0d_rdata", i), rsp_rdata,
                  32'hA5000000 | 32'(i << 8) | 32'(i));
        end
        idle();
        step();

        // Reset with two responses queued: outputs clear at once, data survives
        rsp_rdy = 1'b0;
        drive(32'h10, 1'b0, 32'h0, 4'h0);
        step();
        drive(32'h20, 1'b0, 32'h0, 4'h0);
        step();
        idle();
        check("rr_queued_vld", {31'b0, rsp_vld}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rr_vld_cleared", {31'b0, rsp_vld}, 32'h0);
        check("rr_rdy_cleared", {31'b0, req_rdy}, 32'h0);
        check("rr_rdata_cleared", rsp_rdata, 32'h0);
        step();
        step();
        rst_n = 1'b1;
        rsp_rdy = 1'b1;
        step();
        step();
        check("rr_no_stale", {31'b0, rsp_vld}, 32'h0);
        check("rr_rdy_back", {31'b0, req_rdy}, 32'h1);
        drive(32'h20, 1'b0, 32'h0, 4'h0);
        step();
        idle();
        check("rr_keep_vld", {31'b0, rsp_vld}, 32'h1);
        check("rr_keep_data", rsp_rdata, 32'h1122BBAA);
        step();
        check("rr_end_vld", {31'b0, rsp_vld}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
